i2s_tx_serializer: RTL and testbench

// - Slow-domain stage directly downstream of Data_Fast_to_Slow. Accepts its single-cycle

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_tx_fifo.sv | 44 ++++
 rtl/i2s_tx_serializer.sv | 131 +++++++++++++
 tb/tb_i2s_tx_serializer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the I2S slave transmitter: FSM states, channel tags and the
// tagged FIFO entry (sample data is stored MSB-justified in a fixed-width field).
package i2s_pkg;

  localparam int I2S_MAX_W = 32;

  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_e;

  typedef enum logic {CH_L = 1'b0, CH_R = 1'b1} chan_e;

  typedef struct packed {
    chan_e                tag;
    logic [I2S_MAX_W-1:0] data;
  } entry_t;

  function automatic chan_e flip_ch(input chan_e c);
    return (c == CH_L) ? CH_R : CH_L;
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous FIFO of tagged samples. Pointers carry one extra wrap bit so full
// and empty are told apart without a separate counter.
module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic    Clk,
  input  logic    Rst_N,
  input  logic    push,
  input  logic    pop,
  input  entry_t  wr_entry,
  output entry_t  rd_entry,
  output logic    full,
  output logic    empty,
  output logic [AW:0] level
);

  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge Clk) begin
    if (!Rst_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data-only: contents are don't-care until the pointers say otherwise.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  assign rd_entry = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S slave transmitter: buffers channel-tagged samples and shifts them out MSB
// first, one SCLK after each LRCLK transition, padding the rest of the slot with 0.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SLOT_BITS  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MONO       = 0
) (
  input  logic                                Clk,
  input  logic                                Rst_N,
  input  logic [WIDTH-1:0]                    Data_In,
  input  logic                                Valid_In,
  input  logic                                Lrclk_In,
  output logic                                Sd_Out,
  output logic                                Underrun,
  output logic                                Overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     Fifo_Level
);

  localparam int              CNT_W    = $clog2(SLOT_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam int              MSB      = I2S_MAX_W - 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [I2S_MAX_W-1:0] shift_q;
  logic [I2S_MAX_W-1:0] copy_q, copy_d;
  logic [I2S_MAX_W-1:0] load_word;
  logic                 lrclk_q;
  logic                 sd_q, und_q, ovf_q;
  chan_e                wr_tag_q;
  chan_e                channel;
  logic                 chan_start, slot_go, load, shift_en, starve;
  logic                 pop, push_ok, ovf_d;
  entry_t               head, wr_entry;
  logic                 fifo_full, fifo_empty;

  assign chan_start = (Lrclk_In != lrclk_q);
  assign channel    = chan_e'(Lrclk_In);
  assign push_ok    = Valid_In && (!fifo_full || pop);
  assign ovf_d      = Valid_In && fifo_full && !pop;
  assign wr_entry   = '{tag: wr_tag_q, data: I2S_MAX_W'(Data_In) << (I2S_MAX_W - WIDTH)};

  i2s_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk      (Clk),
    .Rst_N    (Rst_N),
    .push     (push_ok),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (Fifo_Level)
  );

  // Slot start decision: which word (if any) to load and whether the FIFO pops.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    pop       = 1'b0;
    starve    = 1'b0;
    load_word = '0;
    copy_d    = copy_q;
    slot_go   = chan_start && ((state_q != IDLE) || (channel == CH_L));
    shift_en  = (state_q == SHIFT) && !slot_go && (bit_cnt_q != LAST_BIT);
    if (slot_go) begin
      state_d = SHIFT;
      load    = 1'b1;
      if (MONO != 0) begin
        if (channel == CH_R) begin
          load_word = copy_q;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          load_word = head.data;
          copy_d    = head.data;
        end else begin
          starve = 1'b1;
          copy_d = '0;
        end
      end else if (!fifo_empty && (head.tag == channel)) begin
        pop       = 1'b1;
        load_word = head.data;
      end else begin
        starve = 1'b1;
      end
    end else if ((state_q == SHIFT) && (bit_cnt_q == LAST_BIT)) begin
      state_d = PAD;
    end
  end

  always_ff @(posedge Clk) begin
    lrclk_q <= Lrclk_In;
    if (!Rst_N) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sd_q      <= 1'b0;
      und_q     <= 1'b0;
      ovf_q     <= 1'b0;
      wr_tag_q  <= CH_L;
      copy_q    <= '0;
    end else begin
      state_q <= state_d;
      und_q   <= starve;
      ovf_q   <= ovf_d;
      copy_q  <= copy_d;
      if (push_ok && (MONO == 0)) wr_tag_q <= flip_ch(wr_tag_q);
      if (load) begin
        bit_cnt_q <= '0;
        sd_q      <= load_word[MSB];
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        sd_q      <= shift_q[MSB];
      end else begin
        sd_q <= 1'b0;
      end
    end
  end

  // Shifter holds the bits still to be sent after the one currently on Sd_Out.
  always_ff @(posedge Clk) begin
    if (load)          shift_q <= load_word << 1;
    else if (shift_en) shift_q <= shift_q << 1;
  end

  assign Sd_Out   = sd_q;
  assign Underrun = und_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for the I2S transmitter: a stereo instance and a MONO instance
// share stimulus; each scenario task checks its own expected slot contents.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic        valid = 1'b0;
  logic        lrclk = 1'b0;
  logic        sd, und, ovf, sd_m, und_m, ovf_m;
  logic [2:0]  lvl, lvl_m;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] cap, capm;
  int          und_cnt, undm_cnt, ovf_cnt;
  logic [2:0]  lvl_first, lvlm_first;

  always #5 clk = ~clk;

  i2s_tx_serializer #(.WIDTH(16), .SLOT_BITS(32), .FIFO_DEPTH(4), .MONO(0)) dut (
    .Clk(clk), .Rst_N(rst_n), .Data_In(data), .Valid_In(valid), .Lrclk_In(lrclk),
    .Sd_Out(sd), .Underrun(und), .Overflow(ovf), .Fifo_Level(lvl)
  );

  i2s_tx_serializer #(.WIDTH(16), .SLOT_BITS(32), .FIFO_DEPTH(4), .MONO(1)) dut_m (
    .Clk(clk), .Rst_N(rst_n), .Data_In(data), .Valid_In(valid), .Lrclk_In(lrclk),
    .Sd_Out(sd_m), .Underrun(und_m), .Overflow(ovf_m), .Fifo_Level(lvl_m)
  );

  // One LRCLK slot of len SCLK cycles; SD bits are shifted into cap MSB-first.
  task automatic slot(input logic lr, input int len, input logic do_push, input logic [15:0] pd);
    cap = '0; capm = '0; und_cnt = 0; undm_cnt = 0; ovf_cnt = 0;
    @(negedge clk);
    lrclk = lr;
    if (do_push) begin data = pd; valid = 1'b1; end
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      cap  = {cap[30:0], sd};
      capm = {capm[30:0], sd_m};
      und_cnt  += int'(und);
      undm_cnt += int'(und_m);
      ovf_cnt  += int'(ovf);
      if (i == 0) begin lvl_first = lvl; lvlm_first = lvl_m; valid = 1'b0; end
    end
  endtask

  task automatic push(input logic [15:0] d);
    @(negedge clk);
    data = d; valid = 1'b1;
    @(posedge clk); #1;
    ovf_cnt += int'(ovf);
    valid = 1'b0;
  endtask

  task automatic do_reset(input logic lr);
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; lrclk = lr;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = 1'b1; data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); lrclk = ~lrclk;
      @(posedge clk); #1;
      n_checks++; if (sd !== 1'b0) begin n_fail++; $display("FAIL reset_sd cyc%0d: got %b expected 0", i, sd); end
      n_checks++; if ({und, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses cyc%0d: got %b expected 00", i, {und, ovf}); end
      n_checks++; if (lvl !== 3'd0) begin n_fail++; $display("FAIL reset_level cyc%0d: got %0d expected 0", i, lvl); end
    end
    @(negedge clk); valid = 1'b0; lrclk = 1'b1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_checks++; if ({sd, und, ovf, lvl} !== 6'd0) begin n_fail++; $display("FAIL reset_release: got %b expected 000000", {sd, und, ovf, lvl}); end
  endtask

  task automatic test_stereo;
    push(16'hA5C3);
    push(16'h1234);
    n_checks++; if (lvl !== 3'd2) begin n_fail++; $display("FAIL stereo_lvl2: got %0d expected 2", lvl); end
    slot(1'b0, 32, 1'b0, 16'h0);
    n_checks++; if (cap !== 32'hA5C3_0000) begin n_fail++; $display("FAIL stereo_L_bits: got %h expected a5c30000", cap); end
    n_checks++; if (lvl_first !== 3'd1) begin n_fail++; $display("FAIL stereo_lvl1: got %0d expected 1", lvl_first); end
    n_checks++; if (und_cnt != 0) begin n_fail++; $display("FAIL stereo_L_und: got %0d expected 0", und_cnt); end
    slot(1'b1, 32, 1'b0, 16'h0);
    n_checks++; if (cap !== 32'h1234_0000) begin n_fail++; $display("FAIL stereo_R_bits: got %h expected 12340000", cap); end
    n_checks++; if (lvl_first !== 3'd0) begin n_fail++; $display("FAIL stereo_lvl0: got %0d expected 0", lvl_first); end
  endtask

  task automatic test_underrun;
    slot(1'b0, 32, 1'b0, 16'h0);
    n_checks++; if (cap !== 32'h0 || und_cnt != 1) begin n_fail++; $display("FAIL und_empty_L: got bits %h und %0d expected 0 und 1", cap, und_cnt); end
    slot(1'b1, 32, 1'b0, 16'h0);
    n_checks++; if (cap !== 32'h0 || und_cnt != 1) begin n_fail++; $display("FAIL und_empty_R: got bits %h und %0d expected 0 und 1", cap, und_cnt); end
    push(16'h2222);
    slot(1'b0, 32, 1'b0, 16'h0);
    n_checks++; if (cap !== 32'h1111_0000 && cap !== 32'h2222_0000 && und_cnt != 0) begin n_fail++; $display("FAIL und_realign_pre: got %h", cap); end
    n_checks++; if (cap !== 32'h2222_0000 || und_cnt != 0) begin n_fail++; $display("FAIL und_L_tag_ok: got bits %h und %0d expected 22220000 und 0", cap, und_cnt); end
    slot(1'b1, 32, 1'b0, 16'h0);
    n_checks++; if (cap !== 32'h0 || und_cnt != 1) begin n_fail++; $display("FAIL und_empty_R2: got bits %h und %0d expected 0 und 1", cap, und_cnt); end
    push(16'h3333);
    slot(1'b0, 32, 1'b0, 16'h0);
    n_checks++; if (cap !== 32'h0 || und_cnt != 1 || lvl_first !== 3'd1) begin n_fail++; $display("FAIL und_miss_L: got bits %h und %0d lvl %0d expected 0 und 1 lvl 1", cap, und_cnt, lvl_first); end
    slot(1'b1, 32, 1'b0, 16'h0);
    n_checks++; if (cap !== 32'h3333_0000 || und_cnt != 0 || lvl_first !== 3'd0) begin n_fail++; $display("FAIL und_R_sends: got bits %h und %0d lvl %0d expected 33330000 und 0 lvl 0", cap, und_cnt, lvl_first); end
  endtask

  task automatic test_overflow;
    logic [15:0] exp_w [4];
    exp_w[0] = 16'h0002; exp_w[1] = 16'h0003; exp_w[2] = 16'h0004; exp_w[3] = 16'h0006;
    ovf_cnt = 0;
    for (int i = 1; i <= 5; i++) push(16'(i));
    @(posedge clk); #1;
    ovf_cnt += int'(ovf);
    n_checks++; if (lvl !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d expected 4", lvl); end
    n_checks++; if (ovf_cnt != 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_cnt); end
    slot(1'b0, 32, 1'b1, 16'h0006);
    n_checks++; if (ovf_cnt != 0 || lvl_first !== 3'd4) begin n_fail++; $display("FAIL ovf_push_pop: got ovf %0d lvl %0d expected ovf 0 lvl 4", ovf_cnt, lvl_first); end
    n_checks++; if (cap !== 32'h0001_0000) begin n_fail++; $display("FAIL ovf_first_word: got %h expected 00010000", cap); end
    for (int i = 0; i < 4; i++) begin
      slot((i % 2 == 0) ? 1'b1 : 1'b0, 32, 1'b0, 16'h0);
      n_checks++; if (cap !== {exp_w[i], 16'h0} || und_cnt != 0) begin n_fail++; $display("FAIL ovf_drain%0d: got %h und %0d expected %h0000 und 0", i, cap, und_cnt, exp_w[i]); end
    end
    n_checks++; if (lvl !== 3'd0) begin n_fail++; $display("FAIL ovf_drained: got %0d expected 0", lvl); end
  endtask

  task automatic test_mono;
    do_reset(1'b1);
    push(16'h8001);
    n_checks++; if (lvl_m !== 3'd1) begin n_fail++; $display("FAIL mono_lvl: got %0d expected 1", lvl_m); end
    slot(1'b0, 32, 1'b0, 16'h0);
    n_checks++; if (capm !== 32'h8001_0000 || undm_cnt != 0 || lvlm_first !== 3'd0) begin n_fail++; $display("FAIL mono_L: got %h und %0d lvl %0d expected 80010000 und 0 lvl 0", capm, undm_cnt, lvlm_first); end
    slot(1'b1, 32, 1'b0, 16'h0);
    n_checks++; if (capm !== 32'h8001_0000 || undm_cnt != 0) begin n_fail++; $display("FAIL mono_R: got %h und %0d expected 80010000 und 0", capm, undm_cnt); end
    slot(1'b0, 32, 1'b0, 16'h0);
    n_checks++; if (capm !== 32'h0 || undm_cnt != 1) begin n_fail++; $display("FAIL mono_L_empty: got %h und %0d expected 0 und 1", capm, undm_cnt); end
    slot(1'b1, 32, 1'b0, 16'h0);
    n_checks++; if (capm !== 32'h0 || undm_cnt != 0) begin n_fail++; $display("FAIL mono_R_cleared: got %h und %0d expected 0 und 0", capm, undm_cnt); end
  endtask

  task automatic test_reset_mid_and_short_slot;
    logic [15:0] words [4];
    logic        sd_seen;
    words[0] = 16'hABCD; words[1] = 16'h5A5A; words[2] = 16'h9C3F; words[3] = 16'h0F0F;
    do_reset(1'b1);
    push(16'hFFFF);
    push(16'h7777);
    slot(1'b0, 5, 1'b0, 16'h0);
    n_checks++; if (cap[4:0] !== 5'b11111) begin n_fail++; $display("FAIL mid_prefix: got %b expected 11111", cap[4:0]); end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (sd !== 1'b0 || lvl !== 3'd0) begin n_fail++; $display("FAIL mid_reset_edge: got sd %b lvl %0d expected sd 0 lvl 0", sd, lvl); end
    @(negedge clk); rst_n = 1'b1;
    sd_seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; sd_seen |= sd; end
    n_checks++; if (sd_seen !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got %b expected 0", sd_seen); end
    slot(1'b1, 12, 1'b0, 16'h0);
    n_checks++; if (cap[11:0] !== 12'h0 || und_cnt != 0) begin n_fail++; $display("FAIL mid_right_ignored: got %h und %0d expected 0 und 0", cap[11:0], und_cnt); end
    for (int i = 0; i < 4; i++) push(words[i]);
    for (int i = 0; i < 4; i++) begin
      slot((i % 2 == 0) ? 1'b0 : 1'b1, 12, 1'b0, 16'h0);
      n_checks++; if (cap[11:0] !== words[i][15:4] || und_cnt != 0) begin n_fail++; $display("FAIL short_slot%0d: got %h und %0d expected %h und 0", i, cap[11:0], und_cnt, words[i][15:4]); end
    end
  endtask

  initial begin
    test_reset();
    test_stereo();
    test_underrun();
    test_overflow();
    test_mono();
    test_reset_mid_and_short_slot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
